// File: rtl/tx_hop_scheduler.sv
// tx_hop_scheduler: steps the LO DDS phase increment through a programmable hop table,
// muting the DAC while the LO settles and applying output_select changes only at safe points.
//  clock_i/resetn_i          clock, synchronous active-low reset
//  tbl_wr_*_i                hop table write port (pinc + dwell per entry)
//  num_hops_i, loop_en_i     active entry count and wrap/stop-after-one-pass control
//  start_i, stop_i           sequence start / abort pulses
//  req_select_i, sel_update_i requested output_select and its capture strobe
//  lo_dds_phase_inc_o, output_select_o, dac_mute_o  config outputs toward tx_core
//  busy_o, hop_idx_o, hop_strobe_o, done_o          sequence status
module tx_hop_scheduler #(
  parameter int TABLE_DEPTH   = 16,
  parameter int PINC_W        = 16,
  parameter int DWELL_W       = 24,
  parameter int SEL_W         = 5,
  parameter int SETTLE_CYCLES = 8,
  localparam int IDX_W        = $clog2(TABLE_DEPTH)
) (
  input  logic               clock_i,
  input  logic               resetn_i,
  input  logic               tbl_wr_en_i,
  input  logic [IDX_W-1:0]   tbl_wr_addr_i,
  input  logic [PINC_W-1:0]  tbl_wr_pinc_i,
  input  logic [DWELL_W-1:0] tbl_wr_dwell_i,
  input  logic [IDX_W:0]     num_hops_i,
  input  logic               loop_en_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic [SEL_W-1:0]   req_select_i,
  input  logic               sel_update_i,
  output logic [PINC_W-1:0]  lo_dds_phase_inc_o,
  output logic [SEL_W-1:0]   output_select_o,
  output logic               dac_mute_o,
  output logic               busy_o,
  output logic [IDX_W-1:0]   hop_idx_o,
  output logic               hop_strobe_o,
  output logic               done_o
);
  localparam logic [IDX_W:0] DEPTH = (IDX_W+1)'(TABLE_DEPTH);
  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, DWELL} state_t;
  state_t               state_q;
  logic [PINC_W-1:0]    pinc_mem [TABLE_DEPTH];
  logic [DWELL_W-1:0]   dwell_mem [TABLE_DEPTH];
  logic [PINC_W-1:0]    pinc_q;
  logic [SEL_W-1:0]     sel_q, pend_q;
  logic                 pend_vld_q, mute_q, strobe_q, done_q;
  logic [IDX_W-1:0]     ld_idx_q, hop_idx_q;
  logic [DWELL_W-1:0]   dwell_q, cnt_q;
  logic [IDX_W:0]       nh_eff;
  logic                 last_entry;
  always_comb begin
    nh_eff     = num_hops_i == '0 ? (IDX_W+1)'(1) : num_hops_i > DEPTH ? DEPTH : num_hops_i;
    last_entry = ({1'b0, hop_idx_q} + (IDX_W+1)'(1)) >= nh_eff;
  end
  // Table is not reset; a write during LOAD of the same entry lands after the read.
  always_ff @(posedge clock_i) begin
    if (tbl_wr_en_i) begin
      pinc_mem[tbl_wr_addr_i]  <= tbl_wr_pinc_i;
      dwell_mem[tbl_wr_addr_i] <= tbl_wr_dwell_i;
    end
  end
  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      state_q    <= IDLE;
      pinc_q     <= '0;
      sel_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      mute_q     <= 1'b1;
      strobe_q   <= 1'b0;
      done_q     <= 1'b0;
      ld_idx_q   <= '0;
      hop_idx_q  <= '0;
      dwell_q    <= '0;
      cnt_q      <= '0;
    end else begin
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      if (stop_i && state_q != IDLE) begin
        state_q <= IDLE;
        mute_q  <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            mute_q <= 1'b1;
            if (start_i && !stop_i) begin
              state_q  <= LOAD;
              ld_idx_q <= '0;
            end
          end
          LOAD: begin
            pinc_q    <= pinc_mem[ld_idx_q];
            dwell_q   <= dwell_mem[ld_idx_q];
            hop_idx_q <= ld_idx_q;
            strobe_q  <= 1'b1;
            cnt_q     <= DWELL_W'(SETTLE_CYCLES - 1);
            state_q   <= SETTLE;
          end
          SETTLE: begin
            if (cnt_q == '0) begin
              state_q <= DWELL;
              mute_q  <= 1'b0;
              cnt_q   <= dwell_q == '0 ? '0 : dwell_q - 1'b1;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          default: begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - 1'b1;
            end else begin
              mute_q <= 1'b1;
              if (!last_entry) begin
                ld_idx_q <= hop_idx_q + 1'b1;
                state_q  <= LOAD;
              end else if (loop_en_i) begin
                ld_idx_q <= '0;
                state_q  <= LOAD;
              end else begin
                state_q <= IDLE;
                done_q  <= 1'b1;
              end
            end
          end
        endcase
      end
      // Select changes go straight through when idle, otherwise wait for a hop boundary.
      if (state_q == IDLE) begin
        if (sel_update_i) begin
          sel_q      <= req_select_i;
          pend_vld_q <= 1'b0;
        end
      end else if (state_q == LOAD && !stop_i) begin
        if (sel_update_i) sel_q <= req_select_i;
        else if (pend_vld_q) sel_q <= pend_q;
        pend_vld_q <= 1'b0;
      end else if (sel_update_i) begin
        pend_q     <= req_select_i;
        pend_vld_q <= 1'b1;
      end
    end
  end
  assign lo_dds_phase_inc_o = pinc_q;
  assign output_select_o    = sel_q;
  assign dac_mute_o         = mute_q;
  assign busy_o             = state_q != IDLE;
  assign hop_idx_o          = hop_idx_q;
  assign hop_strobe_o       = strobe_q;
  assign done_o             = done_q;
endmodule

// File: tb/tb_tx_hop_scheduler.sv
// tb_tx_hop_scheduler: directed + randomized checks of tx_hop_scheduler against a timeline model.
module tb_tx_hop_scheduler;
  localparam int D = 16, PW = 16, DW = 24, SW = 5, S = 8, IW = 4;
  logic clock = 1'b0, resetn = 1'b0;
  logic tbl_wr_en = 1'b0, loop_en = 1'b0, start = 1'b0, stop = 1'b0, sel_update = 1'b0;
  logic [IW-1:0] tbl_wr_addr = '0;
  logic [PW-1:0] tbl_wr_pinc = '0;
  logic [DW-1:0] tbl_wr_dwell = '0;
  logic [IW:0] num_hops = '0;
  logic [SW-1:0] req_select = '0;
  logic [PW-1:0] pinc;
  logic [SW-1:0] sel;
  logic dac_mute, busy, hop_strobe, done;
  logic [IW-1:0] hop_idx;
  tx_hop_scheduler dut (
    .clock_i(clock), .resetn_i(resetn), .tbl_wr_en_i(tbl_wr_en), .tbl_wr_addr_i(tbl_wr_addr),
    .tbl_wr_pinc_i(tbl_wr_pinc), .tbl_wr_dwell_i(tbl_wr_dwell), .num_hops_i(num_hops),
    .loop_en_i(loop_en), .start_i(start), .stop_i(stop), .req_select_i(req_select),
    .sel_update_i(sel_update), .lo_dds_phase_inc_o(pinc), .output_select_o(sel),
    .dac_mute_o(dac_mute), .busy_o(busy), .hop_idx_o(hop_idx), .hop_strobe_o(hop_strobe),
    .done_o(done));
  always #5 clock = ~clock;
  typedef struct {logic [PW-1:0] pinc; logic [IW-1:0] idx; logic mute, busy, strobe, done;} exp_t;
  int n_chk = 0, n_fail = 0, n_strobe = 0, n_done = 0;
  logic [PW-1:0] m_pinc [D];
  int m_dw [D];
  exp_t q[$];
  logic [PW-1:0] last_pinc = '0;
  logic [IW-1:0] last_idx = '0;
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, "/pinc"}, 32'(pinc), 32'(e.pinc));
    chk({tag, "/idx"}, 32'(hop_idx), 32'(e.idx));
    chk({tag, "/mute"}, 32'(dac_mute), 32'(e.mute));
    chk({tag, "/busy"}, 32'(busy), 32'(e.busy));
    chk({tag, "/strobe"}, 32'(hop_strobe), 32'(e.strobe));
    chk({tag, "/done"}, 32'(done), 32'(e.done));
  endtask
  function automatic exp_t mk(logic [PW-1:0] p, int i, bit m, bit b, bit s, bit d);
    exp_t x;
    x.pinc = p; x.idx = IW'(i); x.mute = m; x.busy = b; x.strobe = s; x.done = d;
    return x;
  endfunction
  task automatic wr(input int a, input logic [PW-1:0] p, input int d);
    tbl_wr_en = 1'b1; tbl_wr_addr = IW'(a); tbl_wr_pinc = p; tbl_wr_dwell = DW'(d);
    tick;
    tbl_wr_en = 1'b0;
    m_pinc[a] = p; m_dw[a] = d;
  endtask
  // Expected per-cycle timeline: LOAD, then per hop strobe+settle, dwell, and LOAD or done.
  task automatic build(input int nh_raw, input bit lp, input int hops);
    int nh, e;
    num_hops = (IW+1)'(nh_raw);
    loop_en = lp;
    nh = nh_raw == 0 ? 1 : (nh_raw > D ? D : nh_raw);
    e = 0;
    q.delete();
    q.push_back(mk(last_pinc, int'(last_idx), 1, 1, 0, 0));
    for (int h = 0; h < hops; h++) begin
      q.push_back(mk(m_pinc[e], e, 1, 1, 1, 0));
      repeat (S - 1) q.push_back(mk(m_pinc[e], e, 1, 1, 0, 0));
      repeat (m_dw[e] < 1 ? 1 : m_dw[e]) q.push_back(mk(m_pinc[e], e, 0, 1, 0, 0));
      last_pinc = m_pinc[e];
      last_idx = IW'(e);
      if (h != hops - 1) begin
        q.push_back(mk(m_pinc[e], e, 1, 1, 0, 0));
        e = (e + 1 < nh) ? e + 1 : 0;
      end else if (!lp) begin
        q.push_back(mk(m_pinc[e], e, 1, 0, 0, 1));
        q.push_back(mk(m_pinc[e], e, 1, 0, 0, 0));
      end
    end
  endtask
  task automatic run_q(input string tag, input int act_at, input int act);
    n_strobe = 0; n_done = 0;
    start = 1'b1;
    foreach (q[i]) begin
      if (i == act_at && act == 1) start = 1'b1;
      if (i == act_at && act == 2) begin
        tbl_wr_en = 1'b1; tbl_wr_addr = '0; tbl_wr_pinc = 16'h7777; tbl_wr_dwell = 24'd3;
      end
      tick;
      start = 1'b0; tbl_wr_en = 1'b0;
      chk_all($sformatf("%s/c%0d", tag, i), q[i]);
      n_strobe += int'(hop_strobe);
      n_done += int'(done);
    end
  endtask
  task automatic stop_chk(input string tag);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    chk_all({tag, "/stop"}, mk(last_pinc, int'(last_idx), 1, 0, 0, 0));
    tick;
    chk_all({tag, "/after"}, mk(last_pinc, int'(last_idx), 1, 0, 0, 0));
  endtask
  initial begin
    int k, nh;
    bit lp;
    for (int i = 0; i < D; i++) begin m_pinc[i] = '0; m_dw[i] = 1; end
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom); stop = 1'($urandom); sel_update = 1'($urandom);
      req_select = SW'($urandom); num_hops = (IW+1)'($urandom); loop_en = 1'($urandom);
      tick;
      chk_all($sformatf("reset%0d", i), mk(0, 0, 1, 0, 0, 0));
      chk($sformatf("reset%0d/sel", i), 32'(sel), 0);
    end
    start = 0; stop = 0; sel_update = 0; req_select = '0;
    resetn = 1'b1;
    tick;
    wr(0, 16'h1000, 10); wr(1, 16'h2000, 20); wr(2, 16'h3000, 5);
    build(3, 0, 3);
    run_q("pass", -1, 0);
    chk("pass/strobes", 32'(n_strobe), 3);
    chk("pass/dones", 32'(n_done), 1);
    build(3, 1, 5);
    run_q("loop", -1, 0);
    chk("loop/dones", 32'(n_done), 0);
    stop_chk("loop");
    // Pending select waits for the next retune.
    loop_en = 1'b1; num_hops = 3;
    start = 1'b1;
    tick;
    start = 1'b0;
    k = 0;
    while (dac_mute && k < 60) begin tick; k++; end
    chk("sel/mute_fell", 32'(k < 60), 1);
    req_select = 5; sel_update = 1'b1;
    tick;
    sel_update = 1'b0; req_select = 0;
    chk("sel/held0", 32'(sel), 0);
    for (k = 0; k < 60; k++) begin
      tick;
      if (hop_strobe) break;
      chk("sel/held", 32'(sel), 0);
    end
    chk("sel/strobe_seen", 32'(hop_strobe), 1);
    chk("sel/applied", 32'(sel), 5);
    chk("sel/pinc", 32'(pinc), 32'h2000);
    last_pinc = 16'h2000; last_idx = 1;
    stop_chk("sel");
    req_select = 12; sel_update = 1'b1;
    chk("sel/idle_before", 32'(sel), 5);
    tick;
    sel_update = 1'b0;
    chk("sel/idle_after", 32'(sel), 12);
    start = 1'b1; stop = 1'b1;
    tick;
    start = 1'b0; stop = 1'b0;
    chk_all("startstop", mk(last_pinc, int'(last_idx), 1, 0, 0, 0));
    tick;
    chk("startstop/busy2", 32'(busy), 0);
    build(3, 0, 3);
    run_q("restart", 5, 1);
    chk("restart/strobes", 32'(n_strobe), 3);
    build(3, 0, 3);
    run_q("ldwr", 1, 2);
    m_pinc[0] = 16'h7777; m_dw[0] = 3;
    build(1, 0, 1);
    run_q("ldwr_new", -1, 0);
    wr(0, 16'hABCD, 0);
    build(0, 0, 1);
    run_q("nh0", -1, 0);
    chk("nh0/strobes", 32'(n_strobe), 1);
    num_hops = 3; loop_en = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    resetn = 1'b0;
    tick;
    resetn = 1'b1;
    chk_all("midrst", mk(0, 0, 1, 0, 0, 0));
    chk("midrst/sel", 32'(sel), 0);
    last_pinc = '0; last_idx = '0;
    build(3, 0, 3);
    run_q("postrst", -1, 0);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < D; i++) wr(i, PW'($urandom), int'($urandom_range(0, 6)));
      nh = int'($urandom_range(0, 20));
      lp = 1'($urandom);
      build(nh, lp, lp ? (nh == 0 ? 1 : (nh > D ? D : nh)) + 2 : (nh == 0 ? 1 : (nh > D ? D : nh)));
      run_q($sformatf("rnd%0d", r), -1, 0);
      if (lp) stop_chk($sformatf("rnd%0d", r));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
